sa_ws_array: RTL and testbench

Parametrised weight-stationary systolic array; the next-generation matrix core of the int8 MPU. It holds a ROWS×COLS weight tile and streams input vectors through it with valid/ready flow control, computing y[j] = Σ_i x[i]·W[i][j] per vector. Input skew and output de-skew are built in, and a load/run/drain controller sequences each tile. It sits between the MPU operand buffers and the result writeback.

---
 rtl/mpu_pkg.sv | 17 +
 rtl/sa_ws_pe.sv | 57 +++++
 rtl/sa_ws_array.sv | 174 +++++++++++++++++
 tb/tb_sa_ws_array.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mpu_pkg.sv
// Shared definitions for the int8 MPU systolic matrix core.
// Holds the tile controller state encoding and the accumulator sizing rule.
// Operand/result typedefs live in the modules, where DW and ACC_W are known.
package mpu_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Smallest accumulator that can hold a full-length dot product without overflow.
  function automatic int acc_w_min(input int dw, input int rows);
    return 2 * dw + $clog2(rows);
  endfunction

endpackage

// File: rtl/sa_ws_pe.sv
// One weight-stationary PE: psum_down = psum + ext(act) * ext(weight), act forwarded right.
// Latency: one cycle for both the activation and the partial sum.
// Backpressure: none; the PE advances every cycle and the controller gates what enters.
module sa_ws_pe
  import mpu_pkg::*;
#(
  parameter int DW    = 8,
  parameter int ACC_W = 19
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             signed_mode,
  input  logic             w_load,
  input  logic [DW-1:0]    w_value,
  input  logic [DW-1:0]    act,
  input  logic [ACC_W-1:0] psum,
  output logic [DW-1:0]    act_right,
  output logic [ACC_W-1:0] psum_down
);

  logic [DW-1:0]        weight;
  logic signed [DW:0]   act_x;
  logic signed [DW:0]   wgt_x;
  logic signed [2*DW+1:0] prod;
  logic [ACC_W-1:0]     prod_acc;

  // Widen both operands by one bit so a single signed multiply covers both modes.
  always_comb begin
    act_x = signed_mode ? {act[DW-1], act} : {1'b0, act};
    wgt_x = signed_mode ? {weight[DW-1], weight} : {1'b0, weight};
  end

  assign prod     = act_x * wgt_x;
  // Signed cast sign-extends; in unsigned mode the product is non-negative so this is a zero-extend.
  assign prod_acc = ACC_W'(prod);

  // Stationary weight, only rewritten by the controller while the array is idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      weight <= '0;
    end else if (w_load) begin
      weight <= w_value;
    end
  end

  // Systolic registers: activation moves right, partial sum moves down.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_right <= '0;
      psum_down <= '0;
    end else begin
      act_right <= act;
      psum_down <= psum + prod_acc;
    end
  end

endmodule

// File: rtl/sa_ws_array.sv
// Weight-stationary ROWSxCOLS systolic array with load/run/drain sequencing and built-in skew/de-skew.
// Latency: a vector accepted at edge k has its result valid in the cycle after edge k+ROWS+COLS-1.
// Backpressure: x_ready only in RUN, w_ready only in IDLE; results are pushed out with no stall.
module sa_ws_array
  import mpu_pkg::*;
#(
  parameter int ROWS  = 8,
  parameter int COLS  = 8,
  parameter int DW    = 8,
  parameter int ACC_W = acc_w_min(DW, ROWS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          signed_mode,
  input  logic                          w_valid,
  output logic                          w_ready,
  input  logic [$clog2(ROWS)-1:0]       w_row,
  input  logic [COLS-1:0][DW-1:0]       w_data,
  input  logic                          x_valid,
  output logic                          x_ready,
  input  logic                          x_last,
  input  logic [ROWS-1:0][DW-1:0]       x_data,
  output logic                          y_valid,
  output logic [COLS-1:0][ACC_W-1:0]    y_data,
  output logic                          busy,
  output logic                          done
);

  localparam int RW  = $clog2(ROWS);
  localparam int LAT = ROWS + COLS;
  localparam int CW  = $clog2(ROWS + COLS);

  typedef logic [DW-1:0]    opnd_t;
  typedef logic [ACC_W-1:0] acc_t;

  state_t          state;
  state_t          state_nxt;
  logic [ROWS-1:0] loaded;
  logic            run_signed;
  logic [CW-1:0]   drain_cnt;
  logic            done_nxt;
  logic            accept;
  logic            start_ok;
  logic            w_load;
  logic [LAT-1:0]  vld;

  // start is judged against the registered mask, so a same-cycle write to the last row does not count.
  assign accept   = x_valid && x_ready;
  assign start_ok = (state == IDLE) && start && (&loaded);
  assign w_load   = w_valid && w_ready;

  // Controller state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Controller next-state: load tile, stream vectors, then wait out the pipeline.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start_ok) state_nxt = RUN;
      RUN:     if (accept && x_last) state_nxt = DRAIN;
      DRAIN:   if (drain_cnt == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Controller outputs; done is raised one cycle early so its register lines up with the last result.
  always_comb begin
    w_ready  = (state == IDLE);
    x_ready  = (state == RUN);
    busy     = (state != IDLE);
    done_nxt = (state == DRAIN) && (drain_cnt == CW'(1));
  end

  // Tile bookkeeping, per-run operand mode, drain countdown and the done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      loaded     <= '0;
      run_signed <= 1'b0;
      drain_cnt  <= '0;
      done       <= 1'b0;
    end else begin
      done <= done_nxt;
      if (w_load) loaded[w_row] <= 1'b1;
      if (start_ok) run_signed <= signed_mode;
      if (accept && x_last) begin
        drain_cnt <= CW'(LAT - 1);
      end else if ((state == DRAIN) && (drain_cnt != '0)) begin
        drain_cnt <= drain_cnt - 1'b1;
      end
    end
  end

  // Valid bit riding alongside each vector's wavefront.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= '0;
    end else begin
      vld <= {vld[LAT-2:0], accept};
    end
  end

  assign y_valid = vld[LAT-1];

  // act_bus[i][j] feeds PE(i,j); the extra column is the unused spill off the right edge.
  opnd_t act_bus  [ROWS][COLS+1];
  acc_t  psum_bus [ROWS+1][COLS];

  for (genvar j = 0; j < COLS; j++) begin : g_top
    assign psum_bus[0][j] = '0;
  end

  for (genvar i = 0; i < ROWS; i++) begin : g_row
    if (i == 0) begin : g_noskew
      // Bubbles inject zeros so an idle wavefront never disturbs a neighbour.
      assign act_bus[0][0] = accept ? x_data[0] : '0;
    end else begin : g_skew
      opnd_t sr [i];

      // Row skew: hold row i back i cycles so it meets the partial sum coming down.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int k = 0; k < i; k++) sr[k] <= '0;
        end else begin
          sr[0] <= accept ? x_data[i] : '0;
          for (int k = 1; k < i; k++) sr[k] <= sr[k-1];
        end
      end

      assign act_bus[i][0] = sr[i-1];
    end

    for (genvar j = 0; j < COLS; j++) begin : g_col
      sa_ws_pe #(
        .DW    (DW),
        .ACC_W (ACC_W)
      ) u_pe (
        .clk         (clk),
        .rst         (rst),
        .signed_mode (run_signed),
        .w_load      (w_load && (w_row == RW'(i))),
        .w_value     (w_data[j]),
        .act         (act_bus[i][j]),
        .psum        (psum_bus[i][j]),
        .act_right   (act_bus[i][j+1]),
        .psum_down   (psum_bus[i+1][j])
      );
    end
  end

  for (genvar j = 0; j < COLS; j++) begin : g_dsk
    localparam int D = COLS - j;
    acc_t dq [D];

    // Column de-skew (COLS-1-j stages) plus the final output register.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int k = 0; k < D; k++) dq[k] <= '0;
      end else begin
        dq[0] <= psum_bus[ROWS][j];
        for (int k = 1; k < D; k++) dq[k] <= dq[k-1];
      end
    end

    assign y_data[j] = dq[D-1];
  end

endmodule

// File: tb/tb_sa_ws_array.sv
// Directed bench for sa_ws_array (8x8, int8, 19-bit results).
// Inputs are driven and outputs sampled on the falling clock edge.
// Results are matched against hand values or a dot-product model, by cycle of arrival.
module tb_sa_ws_array;

  localparam int R   = 8;
  localparam int C   = 8;
  localparam int DW  = 8;
  localparam int AW  = 19;
  localparam int LAT = R + C;

  typedef logic [R-1:0][DW-1:0] xvec_t;
  typedef logic [C-1:0][AW-1:0] yvec_t;
  typedef logic [C-1:0][DW-1:0] wrow_t;
  typedef struct {
    int    due;
    yvec_t y;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start;
  logic        signed_mode;
  logic        w_valid;
  logic        w_ready;
  logic [2:0]  w_row;
  wrow_t       w_data;
  logic        x_valid;
  logic        x_ready;
  logic        x_last;
  xvec_t       x_data;
  logic        y_valid;
  yvec_t       y_data;
  logic        busy;
  logic        done;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   done_due = -1;
  bit   mon_en = 1'b0;
  exp_t q[$];
  logic [DW-1:0] wm [R][C];

  sa_ws_array #(
    .ROWS (R),
    .COLS (C),
    .DW   (DW),
    .ACC_W(AW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .signed_mode(signed_mode),
    .w_valid    (w_valid),
    .w_ready    (w_ready),
    .w_row      (w_row),
    .w_data     (w_data),
    .x_valid    (x_valid),
    .x_ready    (x_ready),
    .x_last     (x_last),
    .x_data     (x_data),
    .y_valid    (y_valid),
    .y_data     (y_data),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%b exp=%b", tag, obs, exp);
    end
  endtask

  task automatic chky(input string tag, input yvec_t obs, input yvec_t exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic yvec_t golden(input xvec_t x, input bit sm);
    yvec_t y;
    int s;
    int a;
    int w;
    for (int j = 0; j < C; j++) begin
      s = 0;
      for (int i = 0; i < R; i++) begin
        if (sm) begin
          a = int'($signed(x[i]));
          w = int'($signed(wm[i][j]));
        end else begin
          a = int'(x[i]);
          w = int'(wm[i][j]);
        end
        s += a * w;
      end
      y[j] = s[AW-1:0];
    end
    return y;
  endfunction

  function automatic xvec_t xv_all(input logic [DW-1:0] v);
    xvec_t x;
    for (int i = 0; i < R; i++) x[i] = v;
    return x;
  endfunction

  function automatic yvec_t yv_all(input logic [AW-1:0] v);
    yvec_t y;
    for (int j = 0; j < C; j++) y[j] = v;
    return y;
  endfunction

  function automatic wrow_t wr_all(input logic [DW-1:0] v);
    wrow_t w;
    for (int j = 0; j < C; j++) w[j] = v;
    return w;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic load_row(input int r, input wrow_t d);
    w_valid = 1'b1;
    w_row   = 3'(r);
    w_data  = d;
    tick();
    w_valid = 1'b0;
    for (int j = 0; j < C; j++) wm[r][j] = d[j];
  endtask

  task automatic do_start(input bit sm);
    start       = 1'b1;
    signed_mode = sm;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input xvec_t xv, input bit last, input yvec_t yv);
    exp_t e;
    x_valid = 1'b1;
    x_last  = last;
    x_data  = xv;
    e.due   = cyc + LAT;
    e.y     = yv;
    q.push_back(e);
    if (last) done_due = cyc + LAT;
    tick();
    x_valid = 1'b0;
    x_last  = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int n = 0; n < 3 * LAT && cyc <= done_due; n++) tick();
    chk1({tag, "_idle_busy"}, busy, 1'b0);
    chk1({tag, "_idle_w_ready"}, w_ready, 1'b1);
  endtask

  // Result/done checker: y_valid must appear exactly on the cycles the bench scheduled.
  always @(negedge clk) begin
    if (mon_en) begin
      bit due;
      due = (q.size() > 0) && (q[0].due == cyc);
      chk1("y_valid", y_valid, due);
      if (due) begin
        chky("y_data", y_data, q[0].y);
        void'(q.pop_front());
      end
      chk1("done", done, cyc == done_due);
    end
  end

  initial begin
    xvec_t xv;
    yvec_t yv;
    wrow_t wr;

    rst         = 1'b1;
    start       = 1'b0;
    signed_mode = 1'b0;
    w_valid     = 1'b0;
    w_row       = '0;
    w_data      = '0;
    x_valid     = 1'b0;
    x_last      = 1'b0;
    x_data      = '0;
    for (int i = 0; i < R; i++)
      for (int j = 0; j < C; j++) wm[i][j] = '0;

    tick();
    tick();
    chk1("rst_w_ready", w_ready, 1'b1);
    chk1("rst_x_ready", x_ready, 1'b0);
    chk1("rst_y_valid", y_valid, 1'b0);
    chky("rst_y_data", y_data, '0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    rst    = 1'b0;
    mon_en = 1'b1;
    tick();

    // Identity tile, unsigned: y[j] = x[j] = j+1.
    for (int i = 0; i < R; i++) begin
      for (int j = 0; j < C; j++) wr[j] = (i == j) ? 8'd1 : 8'd0;
      load_row(i, wr);
    end
    do_start(1'b0);
    chk1("start_x_ready", x_ready, 1'b1);
    chk1("start_busy", busy, 1'b1);
    chk1("run_w_ready", w_ready, 1'b0);
    for (int i = 0; i < R; i++) xv[i] = 8'(i + 1);
    for (int j = 0; j < C; j++) yv[j] = AW'(j + 1);
    send(xv, 1'b1, yv);
    chk1("drain_x_ready", x_ready, 1'b0);
    chk1("drain_busy", busy, 1'b1);
    wait_idle("ident");

    // All -128 (0x80): signed 8*16384, unsigned 8*128*128, both 131072.
    for (int i = 0; i < R; i++) load_row(i, wr_all(8'h80));
    do_start(1'b1);
    send(xv_all(8'h80), 1'b1, yv_all(19'h20000));
    wait_idle("ext_s");
    do_start(1'b0);
    send(xv_all(8'h80), 1'b1, yv_all(19'h20000));
    wait_idle("ext_u");

    // W = 0xFF, x = 1: signed -8, unsigned 8*255 = 2040.
    for (int i = 0; i < R; i++) load_row(i, wr_all(8'hFF));
    do_start(1'b1);
    send(xv_all(8'h01), 1'b1, yv_all(19'h7FFF8));
    wait_idle("ff_s");
    do_start(1'b0);
    send(xv_all(8'h01), 1'b1, yv_all(19'h007F8));
    wait_idle("ff_u");

    // Streaming with random gaps, random tile, signed.
    for (int i = 0; i < R; i++) begin
      for (int j = 0; j < C; j++) wr[j] = 8'($urandom_range(0, 255));
      load_row(i, wr);
    end
    do_start(1'b1);
    for (int n = 0; n < 20; n++) begin
      repeat ($urandom_range(0, 2)) tick();
      for (int i = 0; i < R; i++) xv[i] = 8'($urandom_range(0, 255));
      send(xv, n == 19, golden(xv, 1'b1));
    end
    wait_idle("stream");

    // Tile reuse over two runs; a weight write while busy must be refused.
    do_start(1'b0);
    w_valid = 1'b1;
    w_row   = 3'd0;
    w_data  = wr_all(8'h55);
    chk1("busy_w_ready", w_ready, 1'b0);
    for (int i = 0; i < R; i++) xv[i] = 8'($urandom_range(0, 255));
    send(xv, 1'b0, golden(xv, 1'b0));
    w_valid = 1'b0;
    for (int n = 0; n < 2; n++) begin
      for (int i = 0; i < R; i++) xv[i] = 8'($urandom_range(0, 255));
      send(xv, n == 1, golden(xv, 1'b0));
    end
    wait_idle("reuse1");
    do_start(1'b1);
    for (int n = 0; n < 2; n++) begin
      for (int i = 0; i < R; i++) xv[i] = 8'($urandom_range(0, 255));
      send(xv, n == 1, golden(xv, 1'b1));
    end
    wait_idle("reuse2");

    // Reset during DRAIN with five vectors in flight.
    do_start(1'b0);
    for (int n = 0; n < 5; n++) begin
      for (int i = 0; i < R; i++) xv[i] = 8'($urandom_range(0, 255));
      send(xv, n == 4, golden(xv, 1'b0));
    end
    tick();
    tick();
    q.delete();
    done_due = -1;
    rst = 1'b1;
    #1;
    chk1("mid_rst_w_ready", w_ready, 1'b1);
    chk1("mid_rst_x_ready", x_ready, 1'b0);
    chk1("mid_rst_y_valid", y_valid, 1'b0);
    chky("mid_rst_y_data", y_data, '0);
    chk1("mid_rst_busy", busy, 1'b0);
    chk1("mid_rst_done", done, 1'b0);
    for (int i = 0; i < R; i++)
      for (int j = 0; j < C; j++) wm[i][j] = '0;
    tick();
    rst = 1'b0;
    repeat (LAT + 4) tick();
    do_start(1'b0);
    chk1("post_rst_start_x_ready", x_ready, 1'b0);
    chk1("post_rst_start_busy", busy, 1'b0);

    // Incomplete load: rows 0-6 only, then row 7 together with start, then a real start.
    for (int i = 0; i < R - 1; i++) begin
      for (int j = 0; j < C; j++) wr[j] = 8'(i + j + 1);
      load_row(i, wr);
    end
    do_start(1'b1);
    chk1("partial_start_x_ready", x_ready, 1'b0);
    for (int j = 0; j < C; j++) wr[j] = 8'(R + j);
    w_valid     = 1'b1;
    w_row       = 3'd7;
    w_data      = wr;
    start       = 1'b1;
    signed_mode = 1'b1;
    tick();
    w_valid = 1'b0;
    start   = 1'b0;
    for (int j = 0; j < C; j++) wm[7][j] = wr[j];
    chk1("same_cycle_start_x_ready", x_ready, 1'b0);
    chk1("same_cycle_start_busy", busy, 1'b0);
    do_start(1'b1);
    chk1("full_start_x_ready", x_ready, 1'b1);
    for (int i = 0; i < R; i++) xv[i] = 8'(8'hF0 + i);
    send(xv, 1'b1, golden(xv, 1'b1));
    wait_idle("partial");

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
